// File: rtl/conv_layer_scheduler.sv
// Sequences weight/bias reads for the convolution datapath and tags results with neuron ids.
// Latency: first read one cycle after start; result k appears PIPE_LAT+2 cycles after its read.
// No downstream backpressure: hold stalls issue only, results stream one per cycle to the consumer.
module conv_layer_scheduler #(
   parameter int PIPE_LAT = 34,
   parameter int MAX_OUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  num_out,
   input  logic        hold,
   output logic        busy,
   output logic        done,
   output logic        w_rd_en,
   output logic [7:0]  w_addr,
   output logic [7:0]  dp_id,
   input  logic [31:0] dp_out_data,
   output logic        res_valid,
   output logic [7:0]  res_id,
   output logic [31:0] res_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] id;
   } tag_t;

   // One stage for the weight memory read plus PIPE_LAT datapath stages.
   localparam int DEPTH = PIPE_LAT + 1;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] num_lat;
   logic [7:0] num_clamped;
   logic [7:0] issue_cnt;
   logic [7:0] res_cnt;
   logic       accept;
   tag_t       tag_in;
   tag_t       tag_tail;
   tag_t       tag_pipe [DEPTH];

   // Clamp only matters when MAX_OUT is below the 8-bit range of num_out.
   generate
      if (MAX_OUT < 255) begin : g_clamp
         localparam logic [7:0] MAX_B = 8'(MAX_OUT);
         assign num_clamped = (num_out > MAX_B) ? MAX_B : num_out;
      end else begin : g_noclamp
         assign num_clamped = num_out;
      end
   endgenerate

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign w_addr   = issue_cnt;
   assign tag_in   = '{valid: w_rd_en, id: issue_cnt};
   assign tag_tail = tag_pipe[DEPTH-1];

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the combinational read strobe (hold acts within the same cycle).
   always_comb begin
      state_nxt = state;
      w_rd_en   = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_out != 8'd0) begin
                  accept    = 1'b1;
                  state_nxt = ISSUE;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         ISSUE: begin
            w_rd_en = !hold;
            if (!hold && (issue_cnt == num_lat - 8'd1)) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (res_cnt == num_lat) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Job length latch, issue counter and the informational datapath-input index.
   always_ff @(posedge clk) begin
      if (!reset) begin
         num_lat   <= 8'd0;
         issue_cnt <= 8'd0;
         dp_id     <= 8'd0;
      end else begin
         dp_id <= w_addr;
         if (accept) begin
            num_lat   <= num_clamped;
            issue_cnt <= 8'd0;
         end else if (w_rd_en) begin
            issue_cnt <= issue_cnt + 8'd1;
         end
      end
   end

   // Tag delay line shadowing the datapath; a bubble is pushed on every non-issue cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // Result capture: pair the tail tag with the datapath output; id/data hold between strobes.
   always_ff @(posedge clk) begin
      if (!reset) begin
         res_valid <= 1'b0;
         res_id    <= 8'd0;
         res_data  <= 32'd0;
         res_cnt   <= 8'd0;
      end else begin
         res_valid <= tag_tail.valid;
         if (tag_tail.valid) begin
            res_id   <= tag_tail.id;
            res_data <= dp_out_data;
            res_cnt  <= res_cnt + 8'd1;
         end else if (accept) begin
            res_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler.
// Each job is recorded cycle by cycle relative to its start pulse, then compared against expectations.
// Datapath output is a free-running tagged counter so res_data can be traced to its source cycle.
module tb_conv_layer_scheduler;

   localparam int PIPE_LAT = 34;
   localparam int MAXC     = 600;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  num_out;
   logic        hold;
   logic        busy;
   logic        done;
   logic        w_rd_en;
   logic [7:0]  w_addr;
   logic [7:0]  dp_id;
   logic [31:0] dp_out_data;
   logic        res_valid;
   logic [7:0]  res_id;
   logic [31:0] res_data;

   int tests = 0;
   int fails = 0;

   int unsigned g = 0;

   // recorded observations, indexed by job-relative cycle
   logic        o_rd   [MAXC];
   logic [7:0]  o_addr [MAXC];
   logic [7:0]  o_dpid [MAXC];
   logic        o_rv   [MAXC];
   logic [7:0]  o_rid  [MAXC];
   logic [31:0] o_rdat [MAXC];
   logic [31:0] o_dp   [MAXC];
   logic        o_done [MAXC];
   logic        o_busy [MAXC];

   // expectations
   logic        e_rd   [MAXC];
   logic [7:0]  e_addr [MAXC];
   logic        e_rv   [MAXC];
   logic [7:0]  e_rid  [MAXC];
   logic        e_done [MAXC];
   logic        e_busy [MAXC];

   logic [63:0] hold_mask;
   int          xs0;
   int          xs1;
   int          rst_at;

   conv_layer_scheduler #(.PIPE_LAT(PIPE_LAT), .MAX_OUT(255)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_out     (num_out),
      .hold        (hold),
      .busy        (busy),
      .done        (done),
      .w_rd_en     (w_rd_en),
      .w_addr      (w_addr),
      .dp_id       (dp_id),
      .dp_out_data (dp_out_data),
      .res_valid   (res_valid),
      .res_id      (res_id),
      .res_data    (res_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) g <= g + 1;
   assign dp_out_data = {16'hC0DE, g[15:0]};

   // Drives one job (start in cycle 0) for ncyc cycles, recording outputs at each negedge.
   task automatic run_job(input logic [7:0] n, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         start   = (c == 0) || (c == xs0) || (c == xs1);
         num_out = n;
         hold    = (c < 64) ? hold_mask[c] : 1'b0;
         reset   = (c != rst_at);
         @(negedge clk);
         o_rd[c]   = w_rd_en;
         o_addr[c] = w_addr;
         o_dpid[c] = dp_id;
         o_rv[c]   = res_valid;
         o_rid[c]  = res_id;
         o_rdat[c] = res_data;
         o_dp[c]   = dp_out_data;
         o_done[c] = done;
         o_busy[c] = busy;
         @(posedge clk);
         #1;
      end
      start     = 1'b0;
      hold      = 1'b0;
      reset     = 1'b1;
      hold_mask = '0;
      xs0       = -1;
      xs1       = -1;
      rst_at    = -1;
   endtask

   task automatic clear_exp();
      for (int c = 0; c < MAXC; c++) begin
         e_rd[c] = 1'b0; e_addr[c] = 8'd0; e_rv[c] = 1'b0;
         e_rid[c] = 8'd0; e_done[c] = 1'b0; e_busy[c] = 1'b0;
      end
   endtask

   // Read k at cycle q[k] yields its result PIPE_LAT+2 cycles later; results past busy_to are not expected.
   task automatic add_job(input int q[$], input int done_cyc, input int busy_from, input int busy_to);
      for (int k = 0; k < q.size(); k++) begin
         e_rd[q[k]]   = 1'b1;
         e_addr[q[k]] = 8'(k);
         if (q[k] + PIPE_LAT + 2 <= busy_to) begin
            e_rv[q[k] + PIPE_LAT + 2]  = 1'b1;
            e_rid[q[k] + PIPE_LAT + 2] = 8'(k);
         end
      end
      if (done_cyc >= 0) e_done[done_cyc] = 1'b1;
      for (int c = busy_from; c <= busy_to; c++) e_busy[c] = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; hold = 1'b0; num_out = 8'd0;
      hold_mask = '0; xs0 = -1; xs1 = -1; rst_at = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0)      begin fails++; $display("FAIL rst_done got %b want 0", done); end
      tests++; if (w_rd_en !== 1'b0)   begin fails++; $display("FAIL rst_rd_en got %b want 0", w_rd_en); end
      tests++; if (w_addr !== 8'd0)    begin fails++; $display("FAIL rst_addr got %0d want 0", w_addr); end
      tests++; if (dp_id !== 8'd0)     begin fails++; $display("FAIL rst_dp_id got %0d want 0", dp_id); end
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
      tests++; if (res_id !== 8'd0)    begin fails++; $display("FAIL rst_res_id got %0d want 0", res_id); end
      tests++; if (res_data !== 32'd0) begin fails++; $display("FAIL rst_res_data got %h want 0", res_data); end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_basic();
      int q[$];
      for (int k = 0; k < 4; k++) q.push_back(1 + k);
      clear_exp();
      add_job(q, 41, 1, 41);
      run_job(8'd4, 50);
      for (int c = 0; c < 50; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || (e_rd[c] && o_addr[c] !== e_addr[c])) begin
            fails++; $display("FAIL basic_read c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, o_rd[c], o_addr[c], e_rd[c], e_addr[c]);
         end
         tests++;
         if (o_rv[c] !== e_rv[c] || (e_rv[c] && (o_rid[c] !== e_rid[c] || o_rdat[c] !== o_dp[c-1]))) begin
            fails++; $display("FAIL basic_res c=%0d got v=%b id=%0d d=%h want v=%b id=%0d", c, o_rv[c], o_rid[c], o_rdat[c], e_rv[c], e_rid[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL basic_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (o_dpid[2+k] !== 8'(k)) begin
            fails++; $display("FAIL basic_dp_id k=%0d got %0d want %0d", k, o_dpid[2+k], k);
         end
      end
      // id and data hold after the last strobe
      tests++;
      if (o_rid[45] !== 8'd3 || o_rdat[45] !== o_dp[39]) begin
         fails++; $display("FAIL basic_hold_vals got id=%0d d=%h want id=3 d=%h", o_rid[45], o_rdat[45], o_dp[39]);
      end
   endtask

   task automatic test_hold();
      int q[$];
      q.push_back(1); q.push_back(4); q.push_back(5); q.push_back(6);
      clear_exp();
      add_job(q, 43, 1, 43);
      hold_mask = 64'h0C;
      run_job(8'd4, 50);
      for (int c = 0; c < 50; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || (e_rd[c] && o_addr[c] !== e_addr[c])) begin
            fails++; $display("FAIL hold_read c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, o_rd[c], o_addr[c], e_rd[c], e_addr[c]);
         end
         tests++;
         if (o_rv[c] !== e_rv[c] || (e_rv[c] && (o_rid[c] !== e_rid[c] || o_rdat[c] !== o_dp[c-1]))) begin
            fails++; $display("FAIL hold_res c=%0d got v=%b id=%0d d=%h want v=%b id=%0d", c, o_rv[c], o_rid[c], o_rdat[c], e_rv[c], e_rid[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL hold_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
   endtask

   task automatic test_zero();
      int q[$];
      clear_exp();
      add_job(q, 1, 1, 1);
      run_job(8'd0, 10);
      for (int c = 0; c < 10; c++) begin
         tests++;
         if (o_rd[c] !== 1'b0 || o_rv[c] !== 1'b0) begin
            fails++; $display("FAIL zero_activity c=%0d got rd=%b rv=%b want 0 0", c, o_rd[c], o_rv[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL zero_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
   endtask

   task automatic test_retrigger();
      int q[$];
      for (int k = 0; k < 8; k++) q.push_back(1 + k);
      clear_exp();
      add_job(q, 45, 1, 45);
      xs0 = 5;
      xs1 = 20;
      run_job(8'd8, 55);
      for (int c = 0; c < 55; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || (e_rd[c] && o_addr[c] !== e_addr[c])) begin
            fails++; $display("FAIL retrig_read c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, o_rd[c], o_addr[c], e_rd[c], e_addr[c]);
         end
         tests++;
         if (o_rv[c] !== e_rv[c] || (e_rv[c] && (o_rid[c] !== e_rid[c] || o_rdat[c] !== o_dp[c-1]))) begin
            fails++; $display("FAIL retrig_res c=%0d got v=%b id=%0d d=%h want v=%b id=%0d", c, o_rv[c], o_rid[c], o_rdat[c], e_rv[c], e_rid[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL retrig_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int q[$];
      int q2[$];
      for (int k = 0; k < 8; k++) q.push_back(1 + k);
      clear_exp();
      add_job(q, -1, 1, 20);
      rst_at = 20;
      run_job(8'd8, 60);
      for (int c = 0; c < 60; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || o_rv[c] !== 1'b0 || o_done[c] !== 1'b0 || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL midrst_ctl c=%0d got rd=%b rv=%b done=%b busy=%b want rd=%b rv=0 done=0 busy=%b", c, o_rd[c], o_rv[c], o_done[c], o_busy[c], e_rd[c], e_busy[c]);
         end
         if (c >= 21) begin
            tests++;
            if (o_addr[c] !== 8'd0 || o_dpid[c] !== 8'd0 || o_rid[c] !== 8'd0 || o_rdat[c] !== 32'd0) begin
               fails++; $display("FAIL midrst_vals c=%0d got addr=%0d dp_id=%0d id=%0d d=%h want all 0", c, o_addr[c], o_dpid[c], o_rid[c], o_rdat[c]);
            end
         end
      end
      q2.push_back(1); q2.push_back(2);
      clear_exp();
      add_job(q2, 39, 1, 39);
      run_job(8'd2, 45);
      for (int c = 0; c < 45; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || (e_rd[c] && o_addr[c] !== e_addr[c])) begin
            fails++; $display("FAIL postrst_read c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, o_rd[c], o_addr[c], e_rd[c], e_addr[c]);
         end
         tests++;
         if (o_rv[c] !== e_rv[c] || (e_rv[c] && (o_rid[c] !== e_rid[c] || o_rdat[c] !== o_dp[c-1]))) begin
            fails++; $display("FAIL postrst_res c=%0d got v=%b id=%0d d=%h want v=%b id=%0d", c, o_rv[c], o_rid[c], o_rdat[c], e_rv[c], e_rid[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL postrst_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int q1[$];
      int q2[$];
      // job 1: reads 1..255, done 292; job 2 started at 293: reads 294..548, done 585
      for (int k = 0; k < 255; k++) q1.push_back(1 + k);
      for (int k = 0; k < 255; k++) q2.push_back(294 + k);
      clear_exp();
      add_job(q1, 292, 1, 292);
      add_job(q2, 585, 294, 585);
      xs0 = 293;
      run_job(8'd255, 595);
      for (int c = 0; c < 595; c++) begin
         tests++;
         if (o_rd[c] !== e_rd[c] || (e_rd[c] && o_addr[c] !== e_addr[c])) begin
            fails++; $display("FAIL b2b_read c=%0d got en=%b addr=%0d want en=%b addr=%0d", c, o_rd[c], o_addr[c], e_rd[c], e_addr[c]);
         end
         tests++;
         if (o_rv[c] !== e_rv[c] || (e_rv[c] && (o_rid[c] !== e_rid[c] || o_rdat[c] !== o_dp[c-1]))) begin
            fails++; $display("FAIL b2b_res c=%0d got v=%b id=%0d d=%h want v=%b id=%0d", c, o_rv[c], o_rid[c], o_rdat[c], e_rv[c], e_rid[c]);
         end
         tests++;
         if (o_done[c] !== e_done[c] || o_busy[c] !== e_busy[c]) begin
            fails++; $display("FAIL b2b_ctl c=%0d got done=%b busy=%b want done=%b busy=%b", c, o_done[c], o_busy[c], e_done[c], e_busy[c]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_zero();
      test_retrigger();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
